parking_slot_manager: RTL
=========================

PARKING_SLOT_MANAGER -- requirements
Module: parking_slot_manager

Interface
REQ-001 SHALL have parameter CAPACITY, default 8: number of parking slots.
REQ-002 SHALL have parameter GATE_TIME, default 16: gate-open window in CLOCK cycles while waiting for a car.
REQ-003 SHALL have port CLOCK, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port RESET, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port Green, input, 1: access-granted LED from the access FSM.
REQ-006 SHALL have port INDICATOR, input, 3: access FSM state (000 idle, 001 hold, 010 wrong pwd, 011 right pwd, 100 stop).
REQ-007 SHALL have port car_in_sensor, input, 1: high while a car occupies the entry gate.
REQ-008 SHALL have port car_out_sensor, input, 1: high while a car occupies the exit gate.
REQ-009 SHALL have port gate_open, output, 1: entry barrier raised.
REQ-010 SHALL have port occupancy, output, $clog2(CAPACITY+1) (4 at default): cars parked.
REQ-011 SHALL have port full, output, 1: occupancy == CAPACITY.
REQ-012 SHALL have port empty, output, 1: occupancy == 0.
REQ-013 SHALL have port deny, output, 1: one-cycle pulse on a grant refused because the lot is full.
REQ-014 SHALL have port timeout, output, 1: one-cycle pulse when the gate closes with no car passing.

Function
REQ-015 grant SHALL be Green AND (INDICATOR == 3'b011); a grant event SHALL be its rising edge (registered previous value).
REQ-016 Entry FSM states SHALL be G_IDLE, G_OPEN, G_PASS; gate_open SHALL be 1 exactly in G_OPEN and G_PASS.
REQ-017 In G_IDLE, a grant event with full=0 SHALL go to G_OPEN next cycle and load the timer with GATE_TIME-1.
REQ-018 In G_IDLE, a grant event with full=1 SHALL stay in G_IDLE and assert deny for exactly one cycle.
REQ-019 Grant events arriving in G_OPEN or G_PASS SHALL be ignored, with no deny.
REQ-020 In G_OPEN, car_in_sensor=1 SHALL go to G_PASS; otherwise timer==0 SHALL go to G_IDLE with a one-cycle timeout pulse; otherwise the timer SHALL decrement by 1.
REQ-021 car_in_sensor has priority over timer expiry in the same cycle.
REQ-022 In G_PASS, car_in_sensor=0 SHALL return to G_IDLE and raise an increment request in that cycle; G_PASS has no timeout.
REQ-023 An exit event SHALL be the rising edge of car_out_sensor; it raises a decrement request when occupancy>0 and is ignored when occupancy==0.
REQ-024 Concurrent increment and decrement requests SHALL leave occupancy unchanged.
REQ-025 An increment SHALL saturate at CAPACITY; occupancy never wraps.
REQ-026 full, empty and occupancy SHALL be registered and consistent in the same cycle.
REQ-027 Gate latency SHALL be one cycle from the grant edge to gate_open=1.

Reset
REQ-028 RESET=1 SHALL immediately force: state G_IDLE, timer 0, occupancy 0, gate_open 0, full 0, empty 1, deny 0, timeout 0, edge registers 0.
REQ-029 RESET asserted mid-passage SHALL drop gate_open at once and discard any pending increment.
REQ-030 After RESET deasserts, a grant held high SHALL NOT produce a grant event until it has been seen low.

Structure
REQ-031 A shared package parking_pkg SHALL hold the gate state enum, the INDICATOR codes and the default CAPACITY and GATE_TIME.
REQ-032 One sub-module rise_detect (1-bit registered rising-edge detector, CLOCK/RESET) SHALL be instantiated for grant and for car_out_sensor.

Verification
REQ-033 Reset, grant edge, car_in high for 3 cycles then low -> gate_open rises 1 cycle after the edge, occupancy 0->1, empty falls.
REQ-034 Grant, no car for 16 cycles -> gate_open high for 16 cycles, one timeout pulse, occupancy unchanged.
REQ-035 Fill to 8, then grant -> full=1, one deny pulse, gate_open stays 0.
REQ-036 occupancy=3, G_PASS exit and car_out rising edge in the same cycle -> occupancy stays 3; car_out edge at occupancy 0 -> stays 0.
REQ-037 RESET during G_PASS at occupancy 5 -> occupancy 0 and gate_open 0 immediately; held grant gives no event until it toggles.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared types and constants for the parking slot manager: gate FSM states,
// access-FSM indicator codes and default lot sizing.
package parking_pkg;

    localparam int DEFAULT_CAPACITY  = 8;
    localparam int DEFAULT_GATE_TIME = 16;

    localparam logic [2:0] IND_IDLE      = 3'b000;
    localparam logic [2:0] IND_HOLD      = 3'b001;
    localparam logic [2:0] IND_WRONG_PWD = 3'b010;
    localparam logic [2:0] IND_RIGHT_PWD = 3'b011;
    localparam logic [2:0] IND_STOP      = 3'b100;

    typedef enum logic [1:0] {
        G_IDLE = 2'd0,
        G_OPEN = 2'd1,
        G_PASS = 2'd2
    } gate_state_t;

endpackage

// File: rtl/rise_detect.sv
// Registered 1-bit rising-edge detector. A level that is already high when
// reset releases is not reported until it has first been seen low.
module rise_detect (
    input  logic CLOCK,
    input  logic RESET,
    input  logic din,
    output logic rise
);

    logic prev;
    logic armed;

    // NOTE: clocked state always uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            prev  <= 1'b0;
            armed <= 1'b0;
        end else begin
            prev  <= din;
            armed <= armed | ~din;
        end
    end

    assign rise = din & ~prev & armed;

endmodule

// File: rtl/parking_slot_manager.sv
// Parking lot entry gate controller: opens the barrier on a fresh access grant,
// times out if no car arrives, and tracks lot occupancy from entries and exits.
module parking_slot_manager
    import parking_pkg::*;
#(
    parameter int CAPACITY  = DEFAULT_CAPACITY,
    parameter int GATE_TIME = DEFAULT_GATE_TIME
) (
    input  logic                           CLOCK,
    input  logic                           RESET,
    input  logic                           Green,
    input  logic [2:0]                     INDICATOR,
    input  logic                           car_in_sensor,
    input  logic                           car_out_sensor,
    output logic                           gate_open,
    output logic [$clog2(CAPACITY+1)-1:0]  occupancy,
    output logic                           full,
    output logic                           empty,
    output logic                           deny,
    output logic                           timeout
);

    localparam int OW = $clog2(CAPACITY + 1);
    localparam int TW = (GATE_TIME > 1) ? $clog2(GATE_TIME) : 1;
    localparam logic [OW-1:0] CAP_V      = OW'(CAPACITY);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(GATE_TIME - 1);

    gate_state_t   state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic          grant, grant_evt, exit_evt;
    logic          inc_req, dec_req;
    logic          deny_nxt, timeout_nxt;
    logic [OW-1:0] occ_nxt;

    assign grant = Green & (INDICATOR == IND_RIGHT_PWD);

    rise_detect u_grant_edge (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .din   (grant),
        .rise  (grant_evt)
    );

    rise_detect u_exit_edge (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .din   (car_out_sensor),
        .rise  (exit_evt)
    );

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state   <= G_IDLE;
            timer   <= '0;
            deny    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_nxt;
            timer   <= timer_nxt;
            deny    <= deny_nxt;
            timeout <= timeout_nxt;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        deny_nxt    = 1'b0;
        timeout_nxt = 1'b0;
        inc_req     = 1'b0;
        unique case (state)
            G_IDLE: begin
                if (grant_evt) begin
                    if (full) begin
                        deny_nxt = 1'b1;
                    end else begin
                        state_nxt = G_OPEN;
                        timer_nxt = TIMER_LOAD;
                    end
                end
            end
            G_OPEN: begin
                // A car at the gate wins over an expiring window.
                if (car_in_sensor) begin
                    state_nxt = G_PASS;
                end else if (timer == '0) begin
                    state_nxt   = G_IDLE;
                    timeout_nxt = 1'b1;
                end else begin
                    timer_nxt = timer - TW'(1);
                end
            end
            G_PASS: begin
                if (!car_in_sensor) begin
                    state_nxt = G_IDLE;
                    inc_req   = 1'b1;
                end
            end
            default: state_nxt = G_IDLE;
        endcase
    end

    assign dec_req = exit_evt & (occupancy != '0);

    always_comb begin
        occ_nxt = occupancy;
        if (inc_req && !dec_req) begin
            if (occupancy != CAP_V)
                occ_nxt = occupancy + OW'(1);
        end else if (dec_req && !inc_req) begin
            occ_nxt = occupancy - OW'(1);
        end
    end

    // Flags are derived from the next count so they change on the same edge.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            occupancy <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
        end else begin
            occupancy <= occ_nxt;
            full      <= (occ_nxt == CAP_V);
            empty     <= (occ_nxt == '0);
        end
    end

    assign gate_open = (state == G_OPEN) || (state == G_PASS);

endmodule
